pc_seq: RTL

- Program-counter sequencer and branch/flush controller for the single-issue ARM-subset core.
- Sits between instruction memory and the instruction decoder.
- Owns the PC and the PC of the instruction currently in decode. Consumes the decoder's branch outputs (ib, bl, bv) and drives the decoder's previous-was-branch input (ispb).
- Issues the r14 link write for BL and stalls the front end on hazard or memory wait.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/pc_seq_if.sv | 31 +++
 rtl/sat_counter.sv | 19 +
 rtl/pc_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the front-end sequencer: state encoding,
// word width, pipeline constants and the branch-target helper.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t      PC_INC       = 32'd4;
    localparam word_t      PIPE_OFFSET  = 32'd8;
    localparam logic [3:0] LINK_REG_IDX = 4'd14;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } seq_state_e;

    // The branch is relative to the architectural PC, which is two words past
    // the instruction in decode. The low offset bits are dropped to keep fetch
    // word aligned.
    function automatic word_t branch_target(input word_t dec_pc, input word_t bv);
        return dec_pc + PIPE_OFFSET + {bv[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Fetch/decode/link signal bundle between pc_seq and the surrounding core.
// master = the sequencer, slave = memory, decoder and register file side.
interface pc_seq_if;
    import cpu_pkg::*;

    logic       run;
    logic       imem_valid;
    logic       hazard;
    logic       ib;
    logic       bl;
    word_t      bv;
    word_t      pc_out;
    logic       fetch_req;
    word_t      dec_pc;
    logic       ispb;
    logic       stall;
    logic       link_we;
    logic [3:0] link_addr;
    word_t      link_data;

    modport master (
        input  run, imem_valid, hazard, ib, bl, bv,
        output pc_out, fetch_req, dec_pc, ispb, stall, link_we, link_addr, link_data
    );

    modport slave (
        output run, imem_valid, hazard, ib, bl, bv,
        input  pc_out, fetch_req, dec_pc, ispb, stall, link_we, link_addr, link_data
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clears on rst.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer and branch/flush controller.
// Optional perf counters (br_cnt, stall_cnt) exist only with PC_SEQ_PERF_EN defined.
//
// state | meaning
// RUN   | normal fetch; branches in decode are taken here
// FLUSH | word in decode was fetched behind a branch and is squashed (ispb=1)
// HALT  | run deasserted; fetch off, PC frozen, pending flush remembered
module pc_seq
    import cpu_pkg::*;
#(
    parameter word_t      RESET_VEC = 32'h0000_0000,
    parameter logic [3:0] LINK_REG  = LINK_REG_IDX,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    pc_seq_if.master         bus
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    seq_state_e state_q, state_d;
    word_t      pc_q, pc_d;
    word_t      dec_q, dec_d;
    logic       flush_pend_q, flush_pend_d;
    logic       fetch_c, ispb_c, stall_c, taken_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= {RESET_VEC[WORD_W-1:2], 2'b00};
            dec_q        <= {RESET_VEC[WORD_W-1:2], 2'b00};
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            dec_q        <= dec_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        dec_d        = dec_q;
        flush_pend_d = flush_pend_q;
        fetch_c      = 1'b0;
        ispb_c       = 1'b0;
        stall_c      = 1'b0;
        taken_c      = 1'b0;

        if (rst) begin
            state_d = RUN;
        end else if (!bus.run) begin
            state_d = HALT;
            if (state_q == FLUSH) begin
                flush_pend_d = 1'b1;
            end
        end else if (state_q == HALT) begin
            // One dead cycle after run returns; a squash owed before the halt is re-issued.
            state_d      = flush_pend_q ? FLUSH : RUN;
            flush_pend_d = 1'b0;
        end else begin
            fetch_c = 1'b1;
            ispb_c  = (state_q == FLUSH);
            if (bus.hazard) begin
                stall_c = 1'b1;
            end else if (bus.ib && !ispb_c) begin
                taken_c = 1'b1;
                pc_d    = branch_target(dec_q, bus.bv);
                dec_d   = pc_q;
                state_d = FLUSH;
            end else if (!bus.imem_valid) begin
                stall_c = 1'b1;
            end else begin
                dec_d   = pc_q;
                pc_d    = pc_q + PC_INC;
                state_d = RUN;
            end
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.dec_pc    = dec_q;
    assign bus.fetch_req = fetch_c;
    assign bus.ispb      = ispb_c;
    assign bus.stall     = stall_c;
    assign bus.link_we   = taken_c & bus.bl;
    assign bus.link_addr = LINK_REG;
    assign bus.link_data = dec_q + PC_INC;

    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

`ifdef PC_SEQ_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .inc (taken_c),
        .cnt (br_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_c),
        .cnt (stall_cnt)
    );
`endif

endmodule
